serial_logic_unit: RTL
======================

# serial_logic_unit

Sequential front-end for the team's 1-bit AND/OR selector stage. It accepts two WIDTH-bit operands and an operation select, then streams them LSB-first, one bit per cycle, through a single 1-bit logic cell. It collects the result bits into a WIDTH-bit word and announces completion with a one-cycle `done` pulse. It feeds the bit-level logic cell and consumes its output, and exposes a word-level start/done interface to the surrounding datapath.

## Interface
- `WIDTH`, default 8: operand/result width; legal range WIDTH ≥ 2.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  request; sampled only in IDLE.
- `op_a`  in  WIDTH  operand A; captured when start is accepted.
- `op_b`  in  WIDTH  operand B; captured when start is accepted.
- `select`  in  1  1 = AND, 0 = OR; captured with operands.
- `busy`  out  1  high in SHIFT and DONE.
- `done`  out  1  one-cycle pulse; result valid.
- `result`  out  WIDTH  last completed result; held until next completion.

## Operation
- State machine: IDLE → SHIFT → DONE → IDLE.
- **IDLE:**
  - `start`=1 loads `op_a`/`op_b` into shift registers A_sh/B_sh, latches `select`, clears bit counter and accumulator, then goes to SHIFT.
  - `start`=0 stays in IDLE.
- **SHIFT:**
  - Each cycle the logic cell computes `bit = select ? (A_sh[0] & B_sh[0]) : (A_sh[0] | B_sh[0])`.
  - The accumulator shifts right with `bit` entering at MSB. A_sh and B_sh shift right.
  - Counter increments.
  - When counter == WIDTH-1, `result` loads `{bit, acc[WIDTH-1:1]}`, which is the final word with bit i = op(A[i],B[i]), and the FSM goes to DONE.
- **DONE:** `done`=1 for exactly this cycle, then unconditional return to IDLE.
- Counter width: $clog2(WIDTH); no wrap occurs, since the terminal count is always WIDTH-1.
- `start` in SHIFT or DONE is ignored and is not queued. Operand/select changes after acceptance have no effect.
- `result` changes only on the SHIFT→DONE transition and on reset.
- Reset (`rst_n`=0 at a rising edge) from any state:
  - FSM → IDLE; counter, shift registers, accumulator, latched select → 0.
  - `busy`=0, `done`=0, `result`=0.
  - Any in-flight operation is discarded and produces no `done`.
- `rst_n` low and `start` high at the same edge: reset wins, request dropped.

## Timing
- `start` accepted at edge N → `busy` high from cycle N+1.
- SHIFT occupies cycles N+1 … N+WIDTH.
- DONE is cycle N+WIDTH+1: `done`=1, `result` valid.
- IDLE at N+WIDTH+2; earliest next acceptance is the edge ending cycle N+WIDTH+2.
- Throughput: one operation per WIDTH+2 cycles.
- `busy` and `done` are registered, decoded from state; there is no combinational input→output path.
- Latency from accepting edge to `done` high: WIDTH+1 cycles.

## Structure
- Shared package `logic_unit_pkg` holds:
  - the state enum (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2; 2'd3 is illegal and recovers to IDLE);
  - select constants SEL_AND=1'b1 and SEL_OR=1'b0.
- Sub-module `bit_logic_cell(out_s, in_a, in_b, select)` is purely combinational: an AND/OR pair feeding a 2:1 mux with select=1 choosing AND. It is instantiated once.
- Top level holds the FSM, counter, shift registers, accumulator and result register.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles with `start`=1 → `busy`=0, `done`=0, `result`=8'h00, no `done` after release.
- AND: `op_a`=8'hA5, `op_b`=8'h3C, `select`=1, `start` pulse at edge N → `busy` high for cycles N+1…N+9, `done` high only in cycle N+9, `result`=8'h24 held afterward.
- OR: same operands, `select`=0 → `result`=8'hBD at `done`, exactly 9 cycles after acceptance.
- Busy ignore: start 8'hFF AND 8'h0F, then re-assert `start` with 8'h00/8'h00 OR during SHIFT and DONE → single `done`, `result`=8'h0F, FSM returns to IDLE with no second operation.
- Reset mid-op: start 8'hF0 OR 8'h0F, assert `rst_n`=0 at the 4th SHIFT cycle → `busy`=0 next cycle, `result`=8'h00, no `done`; a subsequent 8'h55 AND 8'hFF completes with `result`=8'h55.
- Back-to-back: issue new `start` in the first IDLE cycle after `done` (8'h81 AND 8'hFF, then 8'h81 OR 8'h7E) → results 8'h81 then 8'hFF, `done` pulses spaced exactly 10 cycles apart.

Source files
------------

// File: rtl/logic_unit_pkg.sv
// Shared types for the serial AND/OR logic unit: FSM state encoding and
// operation-select constants.
package logic_unit_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic SEL_AND = 1'b1;
  localparam logic SEL_OR  = 1'b0;

endpackage

// File: rtl/bit_logic_cell.sv
// Combinational 1-bit logic cell: AND/OR pair feeding a 2:1 mux, select=1 picks AND.
module bit_logic_cell
  import logic_unit_pkg::*;
(
  output logic out_s,
  input  logic in_a,
  input  logic in_b,
  input  logic select
);

  logic and_s;
  logic or_s;

  assign and_s = in_a & in_b;
  assign or_s  = in_a | in_b;
  assign out_s = (select == SEL_AND) ? and_s : or_s;

endmodule

// File: rtl/serial_logic_unit.sv
// Word-level front-end that streams two operands LSB-first through one
// bit_logic_cell and reassembles the result word.
module serial_logic_unit
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             select,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [1:0]       dbg_state
);

  // Handshake: start is a request honoured only in IDLE (operands and select
  // captured on that edge); done is a one-cycle pulse marking result valid.
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_d;
  logic [WIDTH-1:0] result_q;
  logic             sel_q;
  logic             busy_q;
  logic             done_q;
  logic             cell_bit;

  bit_logic_cell u_cell (
    .out_s  (cell_bit),
    .in_a   (a_sh_q[0]),
    .in_b   (b_sh_q[0]),
    .select (sel_q)
  );

  assign cnt_d = cnt_q + CNT_W'(1);
  assign acc_d = {cell_bit, acc_q[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      acc_q    <= '0;
      result_q <= '0;
      sel_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          if (start) begin
            a_sh_q  <= op_a;
            b_sh_q  <= op_b;
            sel_q   <= select;
            cnt_q   <= '0;
            acc_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          a_sh_q <= a_sh_q >> 1;
          b_sh_q <= b_sh_q >> 1;
          acc_q  <= acc_d;
          cnt_q  <= cnt_d;
          // The last bit lands straight in result, so the word is valid in DONE.
          if (cnt_q == LAST_CNT) begin
            result_q <= acc_d;
            done_q   <= 1'b1;
            state_q  <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign dbg_state = state_q;

endmodule
